// File: rtl/uart_rx_word.sv
// ============================================================================
//  Module      : uart_rx_word
//  Description : 8N1 UART receiver that packs BYTE_WIDTH bytes into one word
//                and presents it on a valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_word #(
    parameter int UART_CLK_DIV = 434,
    parameter int BYTE_WIDTH   = 4,
    parameter int BIG_ENDIAN   = 0,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_uart_rx,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [8*BYTE_WIDTH-1:0] o_data,
    output logic                    o_frame_err,
    output logic                    o_overrun
);

    localparam int CNT_W = $clog2(UART_CLK_DIV);
    localparam int IDX_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;

    localparam logic [CNT_W-1:0] c_half_cnt = CNT_W'(UART_CLK_DIV / 2);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(UART_CLK_DIV - 1);
    localparam logic [IDX_W-1:0] c_top_idx  = IDX_W'(BYTE_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_sync1;
    logic                    r_sync2;
    logic [CNT_W-1:0]        r_cnt;
    logic [2:0]              r_bit_idx;
    logic [7:0]              r_shift;
    logic [IDX_W-1:0]        r_idx;
    logic [8*BYTE_WIDTH-1:0] r_word;

    logic                    w_rx;
    logic                    w_bit_tick;
    logic                    w_start_det;
    logic                    w_start_ok;
    logic                    w_data_sample;
    logic                    w_stop_sample;
    logic                    w_byte_ok;
    logic                    w_frame_bad;
    logic                    w_last;
    logic                    w_complete;
    logic                    w_timeout;
    logic [IDX_W-1:0]        w_lane;
    logic [8*BYTE_WIDTH-1:0] w_word_wr;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx        = r_sync2;
    assign w_bit_tick  = (r_cnt == c_last_cnt);
    assign w_start_det = (r_state == ST_IDLE) && !w_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_start_ok    = 1'b0;
        w_data_sample = 1'b0;
        w_stop_sample = 1'b0;
        w_byte_ok     = 1'b0;
        w_frame_bad   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx) w_state_next = ST_START;
            end
            ST_START: begin
                if (r_cnt == c_half_cnt) begin
                    if (w_rx) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                        w_start_ok   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    w_data_sample = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_tick) begin
                    w_stop_sample = 1'b1;
                    if (w_rx) begin
                        w_byte_ok    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_frame_bad  = 1'b1;
                        w_state_next = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (w_rx) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bit timer restarts at every sample point so it never passes UART_CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start_det || w_start_ok || w_data_sample || w_stop_sample) begin
            r_cnt <= '0;
        end else if (r_state == ST_START || r_state == ST_DATA || r_state == ST_STOP) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_start_ok) begin
                r_bit_idx <= '0;
            end else if (w_data_sample) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_data_sample) r_shift <= {w_rx, r_shift[7:1]};
        end
    end

    assign w_lane     = (BIG_ENDIAN != 0) ? (c_top_idx - r_idx) : r_idx;
    assign w_last     = (r_idx == c_top_idx);
    assign w_complete = w_byte_ok && w_last;

    always_comb begin
        w_word_wr                  = r_word;
        w_word_wr[w_lane*8 +: 8]   = r_shift;
    end

    always_ff @(posedge clk) begin
        if (rst || w_timeout) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (w_byte_ok) begin
            r_idx  <= w_last ? '0 : r_idx + 1'b1;
            r_word <= w_last ? '0 : w_word_wr;
        end
    end

    // A finished word may replace the held one only when that one leaves this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (w_complete && (!o_valid || i_ready)) begin
                o_valid <= 1'b1;
                o_data  <= w_word_wr;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            o_frame_err <= w_frame_bad;
            o_overrun   <= w_complete && o_valid && !i_ready;
        end
    end

    generate
        if (TIMEOUT_BITS > 0) begin : g_timeout
            localparam int TO_LIMIT = TIMEOUT_BITS * UART_CLK_DIV;
            localparam int TO_W     = $clog2(TO_LIMIT + 1);
            localparam logic [TO_W-1:0] c_to_hit = TO_W'(TO_LIMIT - 1);

            logic [TO_W-1:0] r_to_cnt;

            always_ff @(posedge clk) begin
                if (rst || w_start_det || (r_idx == '0)) begin
                    r_to_cnt <= '0;
                end else if (r_state == ST_IDLE) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end

            assign w_timeout = (r_state == ST_IDLE) && (r_idx != '0) &&
                               !w_start_det && (r_to_cnt == c_to_hit);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
UART receiver that assembles BYTE_WIDTH consecutive 8N1 bytes into one word and presents it on a valid/ready output. It is the host-to-FPGA counterpart of the existing uart_tx path. Its typical use is feeding the CAN controller tx_valid/tx_data from a PC terminal. It runs entirely in the system clock domain.

Parameters:
UART_CLK_DIV, 434, clk cycles per UART bit; legal range ≥ 4.
BYTE_WIDTH, 4, bytes per output word; legal range 1..8.
BIG_ENDIAN, 0, 0 means the first received byte lands in o_data[7:0]; 1 means it lands in the top byte.
TIMEOUT_BITS, 32, idle bit-times after which a partially assembled word is discarded; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_uart_rx  input  1  asynchronous UART line; idles high
o_valid  output  1  word available
i_ready  input  1  consumer accepts the word
o_data  output  8*BYTE_WIDTH  assembled word
o_frame_err  output  1  one-cycle pulse on a bad stop bit
o_overrun  output  1  one-cycle pulse when a completed word is dropped

Behaviour:
- Reset (rst=1 at a posedge): o_valid=0, o_data=0, o_frame_err=0, o_overrun=0.
  - FSM goes to IDLE; byte index and timeout counter clear.
  - Both synchronizer flops load 1.
  - Reset mid-frame or mid-word drops everything, with no pulses.
- Input path: 2-flop synchronizer; rx_s is the second flop's output. All timing below is referenced to rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE:
    - rx_s=0 → START; the bit counter loads 0.
  - START:
    - At count UART_CLK_DIV/2 (integer divide), sample rx_s.
    - Sample is 1 → glitch; return to IDLE with no pulse.
    - Sample is 0 → DATA; bit index = 0; counter restarts.
  - DATA:
    - Sample every UART_CLK_DIV cycles, so each sample is mid-bit.
    - Data is LSB first; 8 bits are shifted in, then → STOP.
  - STOP:
    - Sample after UART_CLK_DIV cycles.
    - Sample is 1 → byte accepted; → IDLE in the same cycle, so back-to-back frames are supported.
    - Sample is 0 → o_frame_err pulses for 1 cycle and the byte is discarded. The byte index is unchanged, so the partial word is kept. → WAIT_HIGH.
  - WAIT_HIGH:
    - Stay until rx_s=1, then → IDLE.
- Word assembly:
  - Each accepted byte with index k is written to byte lane k; with BIG_ENDIAN=1 it goes to lane BYTE_WIDTH-1-k.
  - k increments, modulo BYTE_WIDTH.
  - On accepting the byte with k=BYTE_WIDTH-1, the word is complete.
- Output register:
  - On word completion with o_valid=0: the next cycle has o_valid=1 and o_data=word.
    - Latency is 1 clk after the stop-bit sample.
  - o_valid and o_data hold stable until the cycle where o_valid&i_ready. o_valid clears after that edge.
  - Completion in the same cycle as o_valid&i_ready: the new word is loaded, o_valid stays 1, and there is no overrun.
  - Completion while o_valid=1 and i_ready=0: the new word is dropped, the held word is unchanged, and o_overrun pulses for 1 cycle.
  - i_ready is ignored while o_valid=0.
- Partial-word timeout (TIMEOUT_BITS>0):
  - The counter runs only in IDLE with k>0. It clears on any start detection.
  - On reaching TIMEOUT_BITS*UART_CLK_DIV, k resets to 0 and the partial lanes are discarded, with no pulse.
- Boundary rules:
  - BYTE_WIDTH=1: every accepted byte completes a word.
  - The bit counter never exceeds UART_CLK_DIV-1.
  - All counters use widths sized with $clog2. There is no wrap except the byte index modulo BYTE_WIDTH.

Test Plan:
1. Word assembly, little-endian. Setup: UART_CLK_DIV=8, BYTE_WIDTH=4, i_ready=1. Stimulus: send bytes 0x78,0x56,0x34,0x12. Response: exactly one o_valid pulse, with o_data=32'h12345678, one clk after the 4th stop-bit sample.
2. Big-endian and back-to-back. Setup: BIG_ENDIAN=1. Stimulus: same four bytes with no idle gap between frames. Response: o_data=32'h78563412; no frame errors.
3. Framing error and glitch rejection.
   - Stimulus: byte 0xA5 sent with its stop bit driven 0. Response: o_frame_err pulses once; the byte is not stored; the next 4 valid bytes yield one correct word.
   - Stimulus: a 2-cycle low glitch in IDLE. Response: no state change visible at any output.
4. Backpressure and overrun. Setup: i_ready=0. Stimulus: send 8 bytes (0x01..0x08). Response: o_data=32'h04030201 is held; o_overrun pulses once at the 8th byte. Then raise i_ready: one transfer occurs and o_valid drops.
5. Timeout. Setup: TIMEOUT_BITS=4. Stimulus: send 2 bytes, idle ≥ 4*8 clks, then send 0x11,0x22,0x33,0x44. Response: o_data=32'h44332211, with no stale lanes.
6. Reset mid-operation. Stimulus: assert rst during the DATA bit of the 3rd byte, then send 4 fresh bytes. Response: all outputs are 0 during reset; the first word after reset contains only the fresh bytes.
